apb_cmd_master: RTL and testbench
=================================

Name: apb_cmd_master

Overview:
- Single-port APB (AMBA3-style, no PSTRB/PSLVERR) requester driven by a 2-bit command input.
- Command 01 issues one read of a fixed address and keeps the returned data in an internal register.
- Command 10 writes that stored value plus one back to the same address.
- Sits between local control logic and one APB completer.

Parameters:
- ADDR, 32'hDEAD_CAFE, fixed target address for all transfers.
- DW, 32, data/address width (paddr_o and pwdata_o share it).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_i  in  2  00 no-op, 01 read, 10 write, 11 invalid (ignored).
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable (access phase).
- paddr_o  out  DW  APB address.
- pwrite_o  out  1  1 = write, 0 = read.
- pwdata_o  out  DW  APB write data.
- pready_i  in  1  completer ready.
- prdata_i  in  DW  completer read data.

Behaviour:
- Reset (sampled at rising edge while reset=1):
  - state IDLE; psel_o, penable_o, pwrite_o = 0; paddr_o, pwdata_o = 0.
  - Internal rdata_q = 0.
  - Reset mid-transfer aborts immediately; no completion, rdata_q cleared.
- All outputs are registered and updated on the same edge as the state register.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - psel_o = 0, penable_o = 0.
  - On an edge with cmd_i=01: go to SETUP with psel_o=1, penable_o=0, paddr_o=ADDR, pwrite_o=0, pwdata_o=0.
  - On an edge with cmd_i=10: go to SETUP with psel_o=1, penable_o=0, paddr_o=ADDR, pwrite_o=1, pwdata_o=rdata_q+1 (mod 2^DW, wraps FFFF_FFFF -> 0).
  - cmd_i 00 or 11: stay IDLE, outputs unchanged.
- SETUP:
  - Lasts exactly one cycle, then unconditionally goes to ACCESS with penable_o=1.
  - paddr_o, pwrite_o, pwdata_o held.
- ACCESS:
  - Hold all outputs while pready_i=0 (unbounded wait states).
  - On an edge with pready_i=1: go to IDLE with psel_o=0, penable_o=0.
  - On that same edge, a read captures prdata_i into rdata_q; a write leaves rdata_q unchanged.
  - paddr_o, pwrite_o and pwdata_o retain their last values in IDLE.
- cmd_i is sampled only in IDLE; changes during SETUP/ACCESS are ignored. No queuing.
- At least one IDLE cycle between transfers. If cmd_i is still 01/10 in IDLE, a new transfer starts (level-triggered).
- pready_i and prdata_i are ignored outside ACCESS, including a late pready_i asserted while IDLE.
- Minimum transfer: 3 cycles from the command-sampling edge (IDLE->SETUP->ACCESS->IDLE) with zero wait states.

Decomposition:
- Package apb_master_pkg holds:
  - state enum {IDLE, SETUP, ACCESS};
  - cmd encodings CMD_NOP=2'b00, CMD_RD=2'b01, CMD_WR=2'b10, CMD_INV=2'b11;
  - default ADDR constant.
- Single module, no sub-modules.

Test Plan:
- Reset: hold reset=1 for 2 cycles -> all outputs 0, no psel_o while cmd_i=00.
- Read: cmd_i=01 for 2 cycles; completer asserts pready_i one cycle after psel_o&penable_o with prdata_i=32'hDEAD_BEEF -> paddr_o=32'hDEAD_CAFE, pwrite_o=0.
  - SETUP then 2 ACCESS cycles; returns to IDLE.
  - rdata_q = DEAD_BEEF, checked via the next write.
- Write after read: cmd_i=10 -> pwrite_o=1, paddr_o=DEAD_CAFE, pwdata_o=32'hDEAD_BEF0, stable through all ACCESS cycles; IDLE after pready_i.
- Write with no prior read, after reset: cmd_i=10 -> pwdata_o=32'h0000_0001.
- Invalid/no-op: cmd_i=11 for 4 cycles, then 00 -> psel_o and penable_o stay 0, no output change.
- Reset mid-transfer: assert reset while in ACCESS with pready_i=0 -> next edge psel_o=0, penable_o=0, outputs 0.
  - A subsequent write then drives pwdata_o=1.

Source files
------------

// File: rtl/apb_master_pkg.sv
// Shared types and constants for the command-driven APB requester.
package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } state_t;

  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_RD  = 2'b01;
  localparam logic [1:0] CMD_WR  = 2'b10;
  localparam logic [1:0] CMD_INV = 2'b11;

  localparam logic [31:0] DEFAULT_ADDR = 32'hDEAD_CAFE;

endpackage

// File: rtl/apb_cmd_master.sv
// APB requester: cmd 01 reads a fixed address into rdata_q, cmd 10 writes rdata_q+1 back.
module apb_cmd_master
  import apb_master_pkg::*;
#(
  parameter int          DW   = 32,
  parameter logic [DW-1:0] ADDR = DW'(DEFAULT_ADDR)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    cmd_i,
  output logic          psel_o,
  output logic          penable_o,
  output logic [DW-1:0] paddr_o,
  output logic          pwrite_o,
  output logic [DW-1:0] pwdata_o,
  input  logic          pready_i,
  input  logic [DW-1:0] prdata_i
);

  state_t        state;
  logic [DW-1:0] rdata_q;

  // Transfer FSM; every output is registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      paddr_o   <= '0;
      pwrite_o  <= 1'b0;
      pwdata_o  <= '0;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          psel_o    <= 1'b0;
          penable_o <= 1'b0;
          case (cmd_i)
            CMD_RD: begin
              state    <= SETUP;
              psel_o   <= 1'b1;
              paddr_o  <= ADDR;
              pwrite_o <= 1'b0;
              pwdata_o <= '0;
            end
            CMD_WR: begin
              state    <= SETUP;
              psel_o   <= 1'b1;
              paddr_o  <= ADDR;
              pwrite_o <= 1'b1;
              pwdata_o <= rdata_q + DW'(1);
            end
            default: begin
              state <= IDLE;
            end
          endcase
        end
        SETUP: begin
          state     <= ACCESS;
          penable_o <= 1'b1;
        end
        ACCESS: begin
          // Completer ready ends the transfer; only reads update the stored value.
          if (pready_i) begin
            state     <= IDLE;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            if (!pwrite_o) begin
              rdata_q <= prdata_i;
            end else begin
              rdata_q <= rdata_q;
            end
          end else begin
            state <= ACCESS;
          end
        end
        default: begin
          state     <= IDLE;
          psel_o    <= 1'b0;
          penable_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed, table-driven bench for apb_cmd_master plus a wait-state sequence.
module tb_apb_cmd_master;

  localparam logic [31:0] A = 32'hDEAD_CAFE;

  logic        clk;
  logic        reset;
  logic [1:0]  cmd_i;
  logic        psel_o;
  logic        penable_o;
  logic [31:0] paddr_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic        pready_i;
  logic [31:0] prdata_i;

  int checks;
  int fails;

  typedef struct {
    logic        rst;
    logic [1:0]  cmd;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_psel;
    logic        e_pen;
    logic        e_pwrite;
    logic [31:0] e_paddr;
    logic [31:0] e_pwdata;
  } vec_t;

  vec_t vecs[$];

  apb_cmd_master dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_i     (cmd_i),
    .psel_o    (psel_o),
    .penable_o (penable_o),
    .paddr_o   (paddr_o),
    .pwrite_o  (pwrite_o),
    .pwdata_o  (pwdata_o),
    .pready_i  (pready_i),
    .prdata_i  (prdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic rst, input logic [1:0] cmd, input logic rdy, input logic [31:0] rdata,
                     input logic ps, input logic pe, input logic pw, input logic [31:0] pa, input logic [31:0] wd);
    vec_t v;
    v.rst = rst; v.cmd = cmd; v.rdy = rdy; v.rdata = rdata;
    v.e_psel = ps; v.e_pen = pe; v.e_pwrite = pw; v.e_paddr = pa; v.e_pwdata = wd;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic ps, input logic pe, input logic pw,
                       input logic [31:0] pa, input logic [31:0] wd);
    logic [66:0] act;
    logic [66:0] exp;
    act = {psel_o, penable_o, pwrite_o, paddr_o, pwdata_o};
    exp = {ps, pe, pw, pa, wd};
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got sel=%b en=%b wr=%b addr=%h wdata=%h, expected sel=%b en=%b wr=%b addr=%h wdata=%h",
               name, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, ps, pe, pw, pa, wd);
    end
  endtask

  task automatic step(input logic rst, input logic [1:0] cmd, input logic rdy, input logic [31:0] rdata);
    @(negedge clk);
    reset = rst; cmd_i = cmd; pready_i = rdy; prdata_i = rdata;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; fails = 0;
    reset = 1'b1; cmd_i = 2'b00; pready_i = 1'b0; prdata_i = 32'h0;

    //  rst cmd   rdy rdata          sel en wr addr   wdata
    add(1'b1, 2'b00, 1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 32'h0, 32'h0);        // reset
    add(1'b1, 2'b01, 1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 32'h0, 32'h0);        // reset beats cmd
    add(1'b0, 2'b00, 1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 32'h0, 32'h0);        // idle nop
    add(1'b0, 2'b10, 1'b0, 32'h0,          1'b1, 1'b0, 1'b1, A, 32'h1);            // write, no prior read
    add(1'b0, 2'b00, 1'b1, 32'h0,          1'b1, 1'b1, 1'b1, A, 32'h1);            // setup ignores pready
    add(1'b0, 2'b00, 1'b0, 32'h0,          1'b1, 1'b1, 1'b1, A, 32'h1);            // wait state
    add(1'b0, 2'b00, 1'b1, 32'h0,          1'b0, 1'b0, 1'b1, A, 32'h1);            // complete, fields kept
    add(1'b0, 2'b11, 1'b0, 32'h0,          1'b0, 1'b0, 1'b1, A, 32'h1);            // invalid
    add(1'b0, 2'b11, 1'b1, 32'h5555_5555,  1'b0, 1'b0, 1'b1, A, 32'h1);            // invalid + late pready
    add(1'b0, 2'b11, 1'b0, 32'h0,          1'b0, 1'b0, 1'b1, A, 32'h1);
    add(1'b0, 2'b11, 1'b0, 32'h0,          1'b0, 1'b0, 1'b1, A, 32'h1);
    add(1'b0, 2'b00, 1'b0, 32'h0,          1'b0, 1'b0, 1'b1, A, 32'h1);            // nop
    add(1'b0, 2'b01, 1'b0, 32'h0,          1'b1, 1'b0, 1'b0, A, 32'h0);            // read setup
    add(1'b0, 2'b01, 1'b0, 32'h0,          1'b1, 1'b1, 1'b0, A, 32'h0);            // access
    add(1'b0, 2'b01, 1'b0, 32'h0,          1'b1, 1'b1, 1'b0, A, 32'h0);            // wait state
    add(1'b0, 2'b10, 1'b1, 32'hDEAD_BEEF,  1'b0, 1'b0, 1'b0, A, 32'h0);            // read done, cmd ignored
    add(1'b0, 2'b10, 1'b0, 32'h0,          1'b1, 1'b0, 1'b1, A, 32'hDEAD_BEF0);    // write captured+1
    add(1'b0, 2'b00, 1'b0, 32'h0,          1'b1, 1'b1, 1'b1, A, 32'hDEAD_BEF0);
    add(1'b0, 2'b00, 1'b0, 32'h0,          1'b1, 1'b1, 1'b1, A, 32'hDEAD_BEF0);
    add(1'b0, 2'b00, 1'b1, 32'h1234_5678,  1'b0, 1'b0, 1'b1, A, 32'hDEAD_BEF0);    // write done, no capture
    add(1'b0, 2'b10, 1'b0, 32'h0,          1'b1, 1'b0, 1'b1, A, 32'hDEAD_BEF0);    // rdata_q unchanged
    add(1'b0, 2'b00, 1'b0, 32'h0,          1'b1, 1'b1, 1'b1, A, 32'hDEAD_BEF0);
    add(1'b1, 2'b00, 1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 32'h0, 32'h0);        // reset mid-access
    add(1'b0, 2'b10, 1'b0, 32'h0,          1'b1, 1'b0, 1'b1, A, 32'h1);            // rdata_q cleared
    add(1'b0, 2'b10, 1'b0, 32'h0,          1'b1, 1'b1, 1'b1, A, 32'h1);
    add(1'b0, 2'b01, 1'b1, 32'h0,          1'b0, 1'b0, 1'b1, A, 32'h1);
    add(1'b0, 2'b01, 1'b0, 32'h0,          1'b1, 1'b0, 1'b0, A, 32'h0);            // level-triggered restart
    add(1'b0, 2'b00, 1'b0, 32'h0,          1'b1, 1'b1, 1'b0, A, 32'h0);
    add(1'b0, 2'b00, 1'b1, 32'hFFFF_FFFF,  1'b0, 1'b0, 1'b0, A, 32'h0);
    add(1'b0, 2'b10, 1'b0, 32'h0,          1'b1, 1'b0, 1'b1, A, 32'h0);            // wraps to 0
    add(1'b0, 2'b00, 1'b0, 32'h0,          1'b1, 1'b1, 1'b1, A, 32'h0);
    add(1'b0, 2'b00, 1'b1, 32'h0,          1'b0, 1'b0, 1'b1, A, 32'h0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].cmd, vecs[i].rdy, vecs[i].rdata);
      check($sformatf("vec%0d", i), vecs[i].e_psel, vecs[i].e_pen, vecs[i].e_pwrite,
            vecs[i].e_paddr, vecs[i].e_pwdata);
    end

    // Read with several wait states, then a bounded wait for completion.
    step(1'b0, 2'b01, 1'b0, 32'h0);
    check("ws_setup", 1'b1, 1'b0, 1'b0, A, 32'h0);
    step(1'b0, 2'b00, 1'b0, 32'h0);
    check("ws_access", 1'b1, 1'b1, 1'b0, A, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 2'b10, 1'b0, 32'h0);
      check($sformatf("ws_hold%0d", k), 1'b1, 1'b1, 1'b0, A, 32'h0);
    end
    begin
      int budget;
      budget = 0;
      step(1'b0, 2'b00, 1'b1, 32'h0000_00FF);
      while (psel_o === 1'b1 && budget < 10) begin
        step(1'b0, 2'b00, 1'b1, 32'h0000_00FF);
        budget++;
      end
      checks++;
      if (budget >= 10) begin
        fails++;
        $display("FAIL ws_timeout: psel still %b after %0d cycles, expected 0", psel_o, budget);
      end
    end
    check("ws_idle", 1'b0, 1'b0, 1'b0, A, 32'h0);
    step(1'b0, 2'b10, 1'b0, 32'h0);
    check("ws_write", 1'b1, 1'b0, 1'b1, A, 32'h0000_0100);
    step(1'b0, 2'b00, 1'b1, 32'h0);
    check("ws_write_acc", 1'b1, 1'b1, 1'b1, A, 32'h0000_0100);
    step(1'b0, 2'b00, 1'b1, 32'h0);
    check("ws_write_done", 1'b0, 1'b0, 1'b1, A, 32'h0000_0100);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
